alu_seq_core: RTL

Parametrised multi-cycle integer ALU: add, sub, multiply (radix-2 Booth) and divide (non-restoring) on WIDTH-bit operands, signed or unsigned per operation. It replaces the fixed 32-bit busy-flag ALU with a valid/ready handshake on both sides, signed/unsigned selection, and divide-by-zero and illegal-op reporting. It sits between the instruction issue stage and writeback; one operation is in flight at a time.

---
 rtl/alu_seq_core.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core
// Multi-cycle integer ALU: add, sub, multiply (radix-2 Booth) and divide
// (non-restoring) on WIDTH-bit operands, signed or unsigned per request.
// One operation in flight; valid/ready handshake on both sides.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   operand_a/_b        operands (dividend/divisor, multiplicand/multiplier)
//   operation           000 add, 001 sub, 010 mul, 011 div, others reserved
//   op_signed           1 = two's-complement operands
//   in_valid/in_ready   request handshake
//   result              2*WIDTH result, {remainder, quotient} for div
//   out_valid/out_ready result handshake
//   div_zero, op_error  status, qualified by out_valid
//   busy                iterating a mul or div
//
// Build option: define ALU_DIV_EN to include the divider. Without it,
// operation 011 completes as a reserved op and div_zero is tied to 0.
module alu_seq_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [2:0]         operation,
    input  logic               op_signed,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               div_zero,
    output logic               op_error,
    output logic               busy
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned RW = WIDTH + 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               err_q, err_d;

    // Booth multiplier: accumulator, left-shifting multiplicand,
    // right-shifting multiplier with the previously examined bit.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic               prev_q, prev_d;
    logic               sgn_q, sgn_d;

    logic [2*WIDTH-1:0] ext_a, ext_b, booth_acc;
    logic               accept, last_iter;

`ifdef ALU_DIV_EN
    // Divider works on magnitudes; signs are reapplied on completion.
    logic               dz_q, dz_d;
    logic [RW-1:0]      rem_q, rem_d, rem_shift, rem_n;
    logic [WIDTH-1:0]   quo_q, quo_d, dvsr_q, dvsr_d, quo_n, rem_fix;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] div_res;
`endif

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;
    assign op_error  = err_q;
`ifdef ALU_DIV_EN
    assign div_zero  = dz_q;
    assign a_neg     = op_signed && operand_a[WIDTH-1];
    assign b_neg     = op_signed && operand_b[WIDTH-1];
`else
    assign div_zero  = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign last_iter = (count_q == CW'(1));
    assign ext_a     = op_signed ? {{WIDTH{operand_a[WIDTH-1]}}, operand_a}
                                 : {{WIDTH{1'b0}}, operand_a};
    assign ext_b     = op_signed ? {{WIDTH{operand_b[WIDTH-1]}}, operand_b}
                                 : {{WIDTH{1'b0}}, operand_b};

    always_comb begin
        booth_acc = acc_q;
        case ({mplr_q[0], prev_q})
            2'b10:   booth_acc = acc_q - mcand_q;
            2'b01:   booth_acc = acc_q + mcand_q;
            default: booth_acc = acc_q;
        endcase
        // The WIDTH+1-bit extended multiplier has a zero top bit when
        // unsigned, which adds one more Booth digit (+M * 2^WIDTH) equal to
        // y[WIDTH-1]; fold it into the final iteration.
        if (last_iter && !sgn_q && mplr_q[0]) begin
            booth_acc = booth_acc + (mcand_q << 1);
        end
    end

`ifdef ALU_DIV_EN
    always_comb begin
        rem_shift = {rem_q[RW-2:0], quo_q[WIDTH-1]};
        if (rem_q[RW-1]) begin
            rem_n = rem_shift + {2'b00, dvsr_q};
        end else begin
            rem_n = rem_shift - {2'b00, dvsr_q};
        end
        quo_n = {quo_q[WIDTH-2:0], ~rem_n[RW-1]};
        // Restoring correction for a negative final remainder is done here,
        // so the last iteration already produces the finished result.
        rem_fix = rem_n[RW-1] ? (rem_n[WIDTH-1:0] + dvsr_q) : rem_n[WIDTH-1:0];
        div_res = {(rneg_q ? -rem_fix : rem_fix), (qneg_q ? -quo_n : quo_n)};
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prev_d   = prev_q;
        sgn_d    = sgn_q;
`ifdef ALU_DIV_EN
        dz_d     = dz_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    result_d = '0;
                    err_d    = 1'b0;
`ifdef ALU_DIV_EN
                    dz_d     = 1'b0;
`endif
                    state_d  = S_DONE;
                    case (operation)
                        OP_ADD: result_d = ext_a + ext_b;
                        OP_SUB: result_d = ext_a - ext_b;
                        OP_MUL: begin
                            acc_d   = '0;
                            mcand_d = ext_a;
                            mplr_d  = operand_b;
                            prev_d  = 1'b0;
                            sgn_d   = op_signed;
                            count_d = CW'(WIDTH);
                            state_d = S_MUL;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (operand_b == '0) begin
                                result_d = {operand_a, {WIDTH{1'b1}}};
                                dz_d     = 1'b1;
                            end else begin
                                rem_d   = '0;
                                quo_d   = a_neg ? -operand_a : operand_a;
                                dvsr_d  = b_neg ? -operand_b : operand_b;
                                qneg_d  = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                count_d = CW'(WIDTH);
                                state_d = S_DIV;
                            end
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                acc_d   = booth_acc;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                prev_d  = mplr_q[0];
                count_d = count_q - CW'(1);
                if (last_iter) begin
                    result_d = booth_acc;
                    state_d  = S_DONE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                rem_d   = rem_n;
                quo_d   = quo_n;
                count_d = count_q - CW'(1);
                if (last_iter) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            prev_q   <= 1'b0;
            sgn_q    <= 1'b0;
`ifdef ALU_DIV_EN
            dz_q     <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            prev_q   <= prev_d;
            sgn_q    <= sgn_d;
`ifdef ALU_DIV_EN
            dz_q     <= dz_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

endmodule
